// File: rtl/dot_matrix_scanner_if.sv
// Scanner bus: divider input, frame-buffer write port, scroll control and LED drive outputs.
interface dot_matrix_scanner_if;
    logic       div_clk;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       scroll_en;
    logic [7:0] row;
    logic [7:0] col;
    logic       frame_start;

    modport master (
        output div_clk, wr_en, wr_row, wr_data, scroll_en,
        input  row, col, frame_start
    );

    modport slave (
        input  div_clk, wr_en, wr_row, wr_data, scroll_en,
        output row, col, frame_start
    );
endinterface

// File: rtl/dot_matrix_scanner.sv
// 8x8 LED dot-matrix scanner: row-by-row multiplexing with blanking gaps and
// optional horizontal scrolling of the frame buffer contents.
module dot_matrix_scanner #(
    parameter int unsigned BLANK_CYC     = 4,
    parameter int unsigned SCROLL_FRAMES = 125
) (
    input  logic                  clk,
    input  logic                  rst,
    dot_matrix_scanner_if.slave   bus
);

    localparam int unsigned BC_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int unsigned FC_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLANK_CYC - 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(SCROLL_FRAMES - 1);

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } state_t;

    state_t          r_state;
    logic            r_div_clk_d;
    logic [7:0]      r_buf [8];
    logic [BC_W-1:0] r_blank_cnt;
    logic [2:0]      r_row_idx;
    logic [FC_W-1:0] r_frame_cnt;
    logic [2:0]      r_offset;
    logic [7:0]      r_row;
    logic [7:0]      r_col;
    logic            r_frame_start;

    state_t          w_state_nxt;
    logic            w_tick;
    logic [7:0]      w_sel;
    logic [7:0]      w_drive_col;
    logic [BC_W-1:0] w_blank_cnt_nxt;
    logic [2:0]      w_row_idx_nxt;
    logic [FC_W-1:0] w_frame_cnt_nxt;
    logic [2:0]      w_offset_nxt;
    logic [7:0]      w_row_nxt;
    logic [7:0]      w_col_nxt;
    logic            w_frame_start_nxt;

    assign w_tick = bus.div_clk & ~r_div_clk_d;

    // Column c shows pixel (c + offset) mod 8; the 3-bit index sum wraps naturally.
    always_comb begin
        w_sel = r_buf[r_row_idx];
        w_drive_col = '1;
        for (int unsigned c = 0; c < 8; c++) begin
            w_drive_col[c] = ~w_sel[3'(c) + r_offset];
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_blank_cnt_nxt   = r_blank_cnt;
        w_row_idx_nxt     = r_row_idx;
        w_frame_cnt_nxt   = bus.scroll_en ? r_frame_cnt : '0;
        w_offset_nxt      = r_offset;
        w_row_nxt         = r_row;
        w_col_nxt         = r_col;
        w_frame_start_nxt = 1'b0;

        case (r_state)
            ST_BLANK: begin
                w_row_nxt = '0;
                w_col_nxt = '1;
                if (r_blank_cnt == BC_LAST) begin
                    w_state_nxt       = ST_DRIVE;
                    w_blank_cnt_nxt   = '0;
                    w_row_nxt         = 8'h01 << r_row_idx;
                    w_col_nxt         = w_drive_col;
                    w_frame_start_nxt = (r_row_idx == 3'd0);
                end else begin
                    w_blank_cnt_nxt = r_blank_cnt + 1'b1;
                end
            end
            ST_DRIVE: begin
                if (w_tick) begin
                    w_state_nxt   = ST_BLANK;
                    w_row_nxt     = '0;
                    w_col_nxt     = '1;
                    w_row_idx_nxt = r_row_idx + 3'd1;
                    if (r_row_idx == 3'd7 && bus.scroll_en) begin
                        if (r_frame_cnt == FC_LAST) begin
                            w_frame_cnt_nxt = '0;
                            w_offset_nxt    = r_offset + 3'd1;
                        end else begin
                            w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= ST_BLANK;
            r_div_clk_d   <= 1'b1;
            r_blank_cnt   <= '0;
            r_row_idx     <= '0;
            r_frame_cnt   <= '0;
            r_offset      <= '0;
            r_row         <= '0;
            r_col         <= '1;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_div_clk_d   <= bus.div_clk;
            r_blank_cnt   <= w_blank_cnt_nxt;
            r_row_idx     <= w_row_idx_nxt;
            r_frame_cnt   <= w_frame_cnt_nxt;
            r_offset      <= w_offset_nxt;
            r_row         <= w_row_nxt;
            r_col         <= w_col_nxt;
            r_frame_start <= w_frame_start_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_buf[i] <= '0;
            end
        end else if (bus.wr_en) begin
            r_buf[bus.wr_row] <= bus.wr_data;
        end
    end

    assign bus.row         = r_row;
    assign bus.col         = r_col;
    assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Directed bench for dot_matrix_scanner with BLANK_CYC=4, SCROLL_FRAMES=2.
module tb_dot_matrix_scanner;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    dot_matrix_scanner_if bus ();

    dot_matrix_scanner #(
        .BLANK_CYC     (4),
        .SCROLL_FRAMES (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] r, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_row  = r;
        bus.wr_data = d;
        step();
        bus.wr_en   = 1'b0;
    endtask

    // Issue one tick in DRIVE, then walk the 4-cycle gap up to the next DRIVE entry.
    task automatic tick_next(input bit extra, input bit wr_entry,
                             input logic [2:0] wrow, input logic [7:0] wdata);
        bus.div_clk = 1'b1;
        step();
        bus.div_clk = 1'b0;
        chk("gap_row", bus.row, 8'h00);
        chk("gap_col", bus.col, 8'hFF);
        step();
        if (extra) bus.div_clk = 1'b1;
        step();
        bus.div_clk = 1'b0;
        if (extra) chk("extra_gap_row", bus.row, 8'h00);
        step();
        if (wr_entry) begin
            bus.wr_en   = 1'b1;
            bus.wr_row  = wrow;
            bus.wr_data = wdata;
        end
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic expect_drive(input string tag, input logic [7:0] r,
                                input logic [7:0] c, input logic fs);
        chk({tag, "_row"}, bus.row, r);
        chk({tag, "_col"}, bus.col, c);
        chk({tag, "_fs"}, {7'd0, bus.frame_start}, {7'd0, fs});
    endtask

    initial begin
        logic [7:0] exp_row;
        logic [7:0] scroll_exp [6];
        int unsigned idx;

        n_tests = 0;
        n_fail  = 0;
        scroll_exp[0] = 8'hFE; scroll_exp[1] = 8'h7F; scroll_exp[2] = 8'h7F;
        scroll_exp[3] = 8'hBF; scroll_exp[4] = 8'hBF; scroll_exp[5] = 8'hDF;

        rst = 1'b0;
        bus.div_clk = 1'b0; bus.wr_en = 1'b0; bus.wr_row = '0;
        bus.wr_data = '0;   bus.scroll_en = 1'b0;
        repeat (3) step();
        expect_drive("rst", 8'h00, 8'hFF, 1'b0);

        // Release: four blank cycles, then row 0 with a one-cycle frame_start.
        rst = 1'b1;
        chk("rel_blank0_row", bus.row, 8'h00);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("rel_blank_row", bus.row, 8'h00);
            chk("rel_blank_col", bus.col, 8'hFF);
        end
        step();
        expect_drive("first_drive", 8'h01, 8'hFF, 1'b1);
        step();
        expect_drive("first_drive_hold", 8'h01, 8'hFF, 1'b0);

        // Loading row 0 mid-DRIVE must not disturb the displayed column.
        for (int i = 0; i < 8; i++) wr(3'(i), 8'h01);
        chk("hold_col", bus.col, 8'hFF);
        chk("hold_row", bus.row, 8'h01);

        for (int i = 1; i <= 8; i++) begin
            idx = i % 8;
            tick_next(1'b0, 1'b0, '0, '0);
            exp_row = 8'h01 << idx;
            expect_drive("scan", exp_row, 8'hFE, idx == 0);
        end

        // Mid-DRIVE write to the displayed row, and write coincident with entry.
        wr(3'd3, 8'h00);
        for (int i = 0; i < 3; i++) tick_next(1'b0, 1'b0, '0, '0);
        expect_drive("row3_empty", 8'h08, 8'hFF, 1'b0);
        wr(3'd3, 8'hAA);
        chk("row3_wr_col", bus.col, 8'hFF);
        step(); step();
        chk("row3_wr_col_late", bus.col, 8'hFF);
        tick_next(1'b0, 1'b1, 3'd4, 8'hFF);
        expect_drive("entry_wr_old", 8'h10, 8'hFE, 1'b0);
        for (int i = 0; i < 7; i++) tick_next(1'b0, 1'b0, '0, '0);
        expect_drive("row3_new", 8'h08, 8'h55, 1'b0);
        tick_next(1'b0, 1'b0, '0, '0);
        expect_drive("entry_wr_new", 8'h10, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) tick_next(1'b0, 1'b0, '0, '0);
        expect_drive("back_row0", 8'h01, 8'hFE, 1'b1);

        // Extra div_clk edge in the gap advances the row only once.
        tick_next(1'b1, 1'b0, '0, '0);
        expect_drive("extra_tick", 8'h02, 8'hFE, 1'b0);
        step(); step(); step();
        chk("extra_no_queue_row", bus.row, 8'h02);
        for (int i = 0; i < 7; i++) tick_next(1'b0, 1'b0, '0, '0);
        expect_drive("pre_scroll", 8'h01, 8'hFE, 1'b1);

        bus.scroll_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 8; i++) tick_next(1'b0, 1'b0, '0, '0);
            chk("scroll_col", bus.col, scroll_exp[f]);
        end

        // Scrolling disabled: offset holds at 3.
        bus.scroll_en = 1'b0;
        for (int i = 0; i < 8; i++) tick_next(1'b0, 1'b0, '0, '0);
        expect_drive("scroll_hold", 8'h01, 8'hDF, 1'b1);

        // One-cycle reset mid-DRIVE clears outputs, offset and buffer.
        rst = 1'b0;
        step();
        rst = 1'b1;
        expect_drive("mid_rst", 8'h00, 8'hFF, 1'b0);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("post_rst_blank", bus.row, 8'h00);
        end
        step();
        expect_drive("post_rst_drive", 8'h01, 8'hFF, 1'b1);
        wr(3'd0, 8'h01);
        tick_next(1'b0, 1'b0, '0, '0);
        expect_drive("post_rst_buf", 8'h02, 8'hFF, 1'b0);
        for (int i = 0; i < 7; i++) tick_next(1'b0, 1'b0, '0, '0);
        expect_drive("post_rst_offset", 8'h01, 8'hFE, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
